pipelined_addsub: RTL

- Parametrised, pipelined successor to the team's 8-bit ripple-carry adder.
- Splits a WIDTH-bit add/subtract into STAGES registered carry-chain segments, so wide datapaths close timing.
- Carries a valid/ready handshake with per-stage bubble collapse, and produces carry, signed-overflow and zero flags.
- Sits between operand-issue logic and any result consumer that can apply backpressure.

---
 rtl/pipelined_addsub.sv | 95 +++++++++
 1 files changed

// File: rtl/pipelined_addsub.sv
// pipelined_addsub: WIDTH-bit add/sub split into STAGES carry-registered segments with valid/ready flow control.
// Define ADDSUB_SAT_EN to add the in_sat port and signed saturation of overflowing results.
module pipelined_addsub #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
`ifdef ADDSUB_SAT_EN
  input  logic             in_sat,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero
);
  localparam int SEG = WIDTH / STAGES;
  localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};
  logic [STAGES-1:0] v, vin, ld;
  logic [WIDTH-1:0] bx, fs, res;
  logic cx, satx, am, bm, ovf;
  assign bx = in_sub ? ~in_b : in_b;
  assign cx = in_sub | in_cin;
`ifdef ADDSUB_SAT_EN
  assign satx = in_sat;
`else
  assign satx = 1'b0;
`endif
  assign in_ready = ld[0];
  assign out_valid = v[STAGES-1];
  for (genvar j = 0; j < STAGES; j++) begin : g_ld
    assign ld[j] = out_ready || !(&v[STAGES-1:j]);
  end
  if (STAGES == 1) begin : g_vin
    assign vin = in_valid;
  end else begin : g_vin
    assign vin = {v[STAGES-2:0], in_valid};
  end
  // st[k] adds slice k; its inputs come from the ports (k=0) or from the register bank between stage k-1 and k
  for (genvar k = 0; k < STAGES; k++) begin : st
    logic [WIDTH-1:k*SEG] a, b;
    logic c, sat;
    logic [SEG:0] r;
    logic [(k+1)*SEG-1:0] s;
    assign r = {1'b0, a[k*SEG +: SEG]} + {1'b0, b[k*SEG +: SEG]} + {{SEG{1'b0}}, c};
    if (k == 0) begin : g
      assign a = in_a;
      assign b = bx;
      assign c = cx;
      assign sat = satx;
      assign s = r[SEG-1:0];
    end else begin : g
      logic [k*SEG-1:0] p;
      always_ff @(posedge clk)
        if (ld[k-1] && vin[k-1]) begin
          a <= st[k-1].a[WIDTH-1:k*SEG];
          b <= st[k-1].b[WIDTH-1:k*SEG];
          c <= st[k-1].r[SEG];
          sat <= st[k-1].sat;
          p <= st[k-1].s;
        end
      assign s = {r[SEG-1:0], p};
    end
  end
  assign fs = st[STAGES-1].s;
  assign am = st[STAGES-1].a[WIDTH-1];
  assign bm = st[STAGES-1].b[WIDTH-1];
  assign ovf = (am == bm) && (fs[WIDTH-1] != am);
  assign res = (st[STAGES-1].sat && ovf) ? (am ? SMIN : SMAX) : fs;
  always_ff @(posedge clk)
    if (rst) begin
      v <= '0;
      out_sum <= '0;
      out_cout <= 1'b0;
      out_ovf <= 1'b0;
      out_zero <= 1'b0;
    end else begin
      v <= (v & ~ld) | (vin & ld);
      if (ld[STAGES-1] && vin[STAGES-1]) begin
        out_sum <= res;
        out_cout <= st[STAGES-1].r[SEG];
        out_ovf <= ovf;
        out_zero <= res == '0;
      end
    end
endmodule
